conv3x3_engine: RTL and testbench
=================================

Name: conv3x3_engine

Overview:
- Parametrised successor to the layer-0 convolution block: 3x3 zero-padded convolution over a square 2^ADDR_W x 2^ADDR_W Q4.16 image, with NUM_KER kernels.
- Kernel weights and biases are runtime-loadable instead of hard-coded.
- Results are saturated, with optional ReLU.
- Sits between the image ROM port and the layer memories. Each kernel k writes its own bank, csel = k+1.

Parameters:
ADDR_W, 6, bits per image dimension; image is 2^ADDR_W square
DW, 20, data/weight width, signed Q4.16
NUM_KER, 2, kernel count (1..4)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a frame when idle
relu_en  in  1  sampled at start; 1 = clamp negative results to 0
busy  out  1  high from cycle after accepted start until done
done  out  1  one-cycle pulse after last write
kw_we  in  1  weight write strobe (honoured only when idle)
kw_addr  in  6  {kernel[1:0], slot[3:0]}; slot 0..8 = taps row-major, slot 9 = bias; slots 10..15 ignored
kw_data  in  DW  signed Q4.16 weight/bias
iaddr  out  2*ADDR_W  image address {row,col}
idata  in  DW  image data, valid one cycle after iaddr
cwr  out  1  layer-memory write strobe
caddr_wr  out  2*ADDR_W  write address {row,col}
cdata_wr  out  DW  result
csel  out  3  target bank, k+1 during writes; 0 otherwise

Behaviour:
- Reset (reset low at clk edge):
  - state IDLE; busy, done, cwr = 0; csel = 0; iaddr, caddr_wr, cdata_wr = 0.
  - All weights/biases = 0; row, col, k, tap counter = 0.
  - Reset mid-frame aborts immediately. No further writes occur.
- States:
  - IDLE: start=1 -> FETCH. Latch relu_en, busy=1, row=col=k=0.
  - FETCH: 9 cycles, cnt 0..8. Drive iaddr = {row+dr, col+dc} for tap cnt, with dr,dc in {-1,0,+1}; address wraps modulo 2^ADDR_W. If cnt>0, accumulate tap cnt-1.
  - DRAIN: accumulate tap 8, add bias<<16.
  - WRITE: cwr=1, caddr_wr={row,col}, csel=k+1, cdata_wr=result, all for exactly one cycle.
    - If k<NUM_KER-1: k++, -> FETCH.
    - Else k=0, advance col, then row at col wrap. If last pixel -> DONE, otherwise -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Timing:
  - 11 cycles per output. Frame = 11*NUM_KER*4^ADDR_W cycles from start to done.
  - Default: 90112 cycles.
- Padding: a tap with row+dr or col+dc outside 0..2^ADDR_W-1 contributes 0. iaddr may still toggle; idata is masked, not trusted.
- Arithmetic:
  - product = signed DW x signed DW (Q8.32).
  - Accumulator is 44-bit signed, cleared at FETCH cnt=0. Bias is sign-extended and shifted left 16.
  - Rounding: r = acc[35+8:16] + acc[15], half-up.
  - Saturation: r > 20'h7FFFF -> 20'h7FFFF; r < -2^19 -> 20'h80000.
  - If relu_en: negative -> 0.
- Boundaries:
  - start while busy: ignored.
  - kw_we while busy: ignored, weights unchanged.
  - kw_we and start in the same idle cycle: the write takes effect and the frame uses the new value.
  - kw_addr kernel >= NUM_KER: ignored.
- cwr is never high outside WRITE; csel returns to 0 the cycle after each write.

Test Plan:
All tests use ADDR_W=2 (4x4), NUM_KER=2.
1. Kernel 0: all taps 20'h10000, bias 0. idata = 20'h10000 everywhere.
   -> (0,0) = 20'h40000, (0,1) = 20'h60000, (1,1) = 9.0 saturated = 20'h7FFFF.
   -> csel=1 on each write; exactly 16 writes per kernel.
2. Kernel 1: all taps 20'hF8000 (-0.5), bias 0, same image.
   - relu_en=0 -> (0,0) = 20'hE0000.
   - relu_en=1 -> (0,0) = 20'h00000.
   - csel=2.
3. Rounding: kernel 0 center tap = 20'h00001, others 0, idata = 20'h08000. -> every output = 20'h00001.
   - Same with bias 20'hFFFFF -> 20'h00000.
4. Timing: one start pulse.
   -> busy high for 352 cycles; done pulses once at cycle 353.
   -> writes every 11 cycles, addresses ordered 0,0,1,1,...,15,15 (kernel 0 then kernel 1 per pixel).
   -> second start mid-frame has no effect.
5. Reset mid-frame: drive reset=0 at the 5th write.
   -> next edge: busy=0, cwr=0, csel=0, weights read back as zero.
   -> a new start with no weights loaded writes all 20'h00000.
6. Load while busy: kw_we during frame changes a tap to 20'h10000.
   -> frame outputs are unaffected; the following frame also uses the old weights.

Source files
------------

// File: rtl/conv3x3_engine.sv
// rtl/conv3x3_engine.sv - 3x3 zero-padded convolution engine with runtime-loadable kernels
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   start, relu_en    frame start pulse (idle only); ReLU select latched at start
//   busy, done        frame in progress; one-cycle completion pulse
//   kw_we/addr/data   weight/bias load port {kernel, slot}, honoured only when idle
//   iaddr, idata      image read port {row,col}; data returns one cycle later
//   cwr, caddr_wr,
//   cdata_wr, csel    layer-memory write port; csel = kernel+1 during a write
module conv3x3_engine #(
  parameter int ADDR_W  = 6,
  parameter int DW      = 20,
  parameter int NUM_KER = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  relu_en,
  output logic                  busy,
  output logic                  done,
  input  logic                  kw_we,
  input  logic [5:0]            kw_addr,
  input  logic [DW-1:0]         kw_data,
  output logic [2*ADDR_W-1:0]   iaddr,
  input  logic [DW-1:0]         idata,
  output logic                  cwr,
  output logic [2*ADDR_W-1:0]   caddr_wr,
  output logic [DW-1:0]         cdata_wr,
  output logic [2:0]            csel
);

  localparam int ACC_W = 44;
  localparam int RW    = ACC_W - 15;
  localparam logic signed [RW-1:0]  SAT_MAX = RW'((1 << (DW-1)) - 1);
  localparam logic signed [RW-1:0]  SAT_MIN = -SAT_MAX - RW'(1);
  localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'(1 << 15);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                 state;
  logic [ADDR_W-1:0]      row, col;
  logic [1:0]             k;
  logic [3:0]             cnt;
  logic                   relu_q;
  logic signed [ACC_W-1:0] acc;

  // Sized for the 4-kernel maximum; banks at or above NUM_KER are never written.
  logic signed [DW-1:0]   weight [4][9];
  logic signed [DW-1:0]   bias   [4];

  logic [1:0] kw_ker;
  logic [3:0] kw_slot;
  assign kw_ker  = kw_addr[5:4];
  assign kw_slot = kw_addr[3:0];

  // Image address of tap t (row-major 3x3), wrapping modulo the image size.
  function automatic logic [2*ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] r,
                                                   input logic [ADDR_W-1:0] c,
                                                   input logic [3:0] t);
    logic [ADDR_W-1:0] rr, cc;
    rr = r + ADDR_W'(t / 4'd3) - ADDR_W'(1);
    cc = c + ADDR_W'(t % 4'd3) - ADDR_W'(1);
    return {rr, cc};
  endfunction

  // Tap t lies inside the image (otherwise it is zero padding).
  function automatic logic tap_ok(input logic [ADDR_W-1:0] r,
                                  input logic [ADDR_W-1:0] c,
                                  input logic [3:0] t);
    logic [3:0] dr, dc;
    dr = t / 4'd3;
    dc = t % 4'd3;
    return !((r == '0 && dr == 4'd0) || (&r && dr == 4'd2) ||
             (c == '0 && dc == 4'd0) || (&c && dc == 4'd2));
  endfunction

  logic [3:0]               tap_idx;
  logic signed [DW-1:0]     pix;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACC_W-1:0]  acc_sum, acc_fin;
  logic signed [RW-1:0]     rnd;
  logic [DW-1:0]            sat, result;
  logic [ADDR_W-1:0]        row_n, col_n;

  always_comb begin
    // idata in FETCH cnt belongs to the tap addressed one cycle earlier.
    tap_idx = 4'd0;
    if (state == S_DRAIN)
      tap_idx = 4'd8;
    else if (cnt != 4'd0)
      tap_idx = cnt - 4'd1;
    pix     = tap_ok(row, col, tap_idx) ? idata : '0;
    prod    = weight[k][tap_idx] * pix;
    acc_sum = acc + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
    acc_fin = acc_sum + {{(ACC_W-DW-16){bias[k][DW-1]}}, bias[k], 16'b0};
    // Half-up rounding: floor((acc + 2^15) / 2^16), kept one bit wider to avoid wrap.
    rnd     = RW'(($signed({acc_fin[ACC_W-1], acc_fin}) + HALF) >>> 16);
    if (rnd > SAT_MAX)
      sat = SAT_MAX[DW-1:0];
    else if (rnd < SAT_MIN)
      sat = SAT_MIN[DW-1:0];
    else
      sat = rnd[DW-1:0];
    result = (relu_q && sat[DW-1]) ? '0 : sat;
    col_n  = col + ADDR_W'(1);
    row_n  = (&col) ? row + ADDR_W'(1) : row;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'd0;
      iaddr    <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      row      <= '0;
      col      <= '0;
      k        <= 2'd0;
      cnt      <= 4'd0;
      acc      <= '0;
      relu_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bias[i] <= '0;
        for (int j = 0; j < 9; j++)
          weight[i][j] <= '0;
      end
    end else begin
      // Loads are accepted in IDLE, including the cycle start is taken.
      if (state == S_IDLE && kw_we && 32'(kw_ker) < NUM_KER && kw_slot <= 4'd9) begin
        if (kw_slot == 4'd9)
          bias[kw_ker] <= kw_data;
        else
          weight[kw_ker][kw_slot] <= kw_data;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FETCH;
            busy   <= 1'b1;
            relu_q <= relu_en;
            row    <= '0;
            col    <= '0;
            k      <= 2'd0;
            cnt    <= 4'd0;
            iaddr  <= tap_addr('0, '0, 4'd0);
          end
        end
        S_FETCH: begin
          if (cnt == 4'd0)
            acc <= '0;
          else
            acc <= acc_sum;
          if (cnt == 4'd8) begin
            state <= S_DRAIN;
          end else begin
            cnt   <= cnt + 4'd1;
            iaddr <= tap_addr(row, col, cnt + 4'd1);
          end
        end
        S_DRAIN: begin
          state    <= S_WRITE;
          cwr      <= 1'b1;
          csel     <= 3'(k) + 3'd1;
          caddr_wr <= {row, col};
          cdata_wr <= result;
        end
        S_WRITE: begin
          cwr  <= 1'b0;
          csel <= 3'd0;
          cnt  <= 4'd0;
          if (32'(k) < NUM_KER - 1) begin
            k     <= k + 2'd1;
            state <= S_FETCH;
            iaddr <= tap_addr(row, col, 4'd0);
          end else begin
            k   <= 2'd0;
            col <= col_n;
            row <= row_n;
            if (&row && &col) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state <= S_FETCH;
              iaddr <= tap_addr(row_n, col_n, 4'd0);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// tb/tb_conv3x3_engine.sv - directed self-checking bench for conv3x3_engine (4x4 image, 2 kernels)
module tb_conv3x3_engine;

  localparam int ADDR_W  = 2;
  localparam int DW      = 20;
  localparam int NUM_KER = 2;
  localparam int NPIX    = 16;
  localparam int NWR     = NPIX * NUM_KER;

  logic                clk = 1'b0;
  logic                reset, start, relu_en, kw_we;
  logic [5:0]          kw_addr;
  logic [DW-1:0]       kw_data, idata;
  logic                busy, done, cwr;
  logic [2*ADDR_W-1:0] iaddr, caddr_wr;
  logic [DW-1:0]       cdata_wr;
  logic [2:0]          csel;

  conv3x3_engine #(.ADDR_W(ADDR_W), .DW(DW), .NUM_KER(NUM_KER)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .busy(busy), .done(done), .kw_we(kw_we), .kw_addr(kw_addr), .kw_data(kw_data),
    .iaddr(iaddr), .idata(idata), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel)
  );

  always #5 clk = ~clk;

  // Image ROM: registered read, data one cycle after address.
  logic [DW-1:0] img [NPIX];
  always @(posedge clk) idata <= img[iaddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write / status monitor on the falling edge.
  logic [3:0]    wr_addr [512];
  logic [DW-1:0] wr_data [512];
  logic [2:0]    wr_sel  [512];
  int            wr_cyc  [512];
  int wcnt = 0, busy_cnt = 0, done_cnt = 0, done_cyc = 0, bad_csel = 0;
  always @(negedge clk) begin
    if (cwr) begin
      if (wcnt < 512) begin
        wr_addr[wcnt] = caddr_wr;
        wr_data[wcnt] = cdata_wr;
        wr_sel[wcnt]  = csel;
        wr_cyc[wcnt]  = cyc;
      end
      wcnt++;
    end else if (csel != 3'd0) begin
      bad_csel++;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_vec = 0, n_err = 0;
  int s_cyc, wbase, bbase, dbase;
  logic [DW-1:0] exp0 [NPIX];
  logic [DW-1:0] exp1 [NPIX];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic kw(input logic [1:0] ker, input logic [3:0] slot, input logic [DW-1:0] d);
    kw_we = 1'b1; kw_addr = {ker, slot}; kw_data = d;
    tick();
    kw_we = 1'b0;
  endtask

  task automatic load_kernel(input logic [1:0] ker, input logic [DW-1:0] tap, input logic [DW-1:0] b);
    for (int t = 0; t < 9; t++) kw(ker, 4'(t), tap);
    kw(ker, 4'd9, b);
  endtask

  // In-range neighbour count of pixel p in a 4x4 image.
  function automatic int nbr(input int p);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (p/4 + dr >= 0 && p/4 + dr < 4 && p%4 + dc >= 0 && p%4 + dc < 4) n++;
    return n;
  endfunction

  // mode: 0 plain, 1 second start mid-frame, 2 weight load mid-frame, 3 bias load with start
  task automatic run_frame(input logic relu, input int mode);
    int n;
    start = 1'b1; relu_en = relu;
    if (mode == 3) begin
      kw_we = 1'b1; kw_addr = {2'd0, 4'd9}; kw_data = 20'hFFFFF;
    end
    s_cyc = cyc; wbase = wcnt; bbase = busy_cnt; dbase = done_cnt;
    tick();
    start = 1'b0; relu_en = 1'b0; kw_we = 1'b0;
    if (mode == 1 || mode == 2) begin
      repeat (100) tick();
      if (mode == 1) begin
        start = 1'b1; tick(); start = 1'b0;
      end else begin
        kw(2'd0, 4'd0, 20'h10000);
      end
    end
    n = 0;
    while (done_cnt == dbase && n < 1000) begin
      tick();
      n++;
    end
    chk("frame_done_seen", 32'(done_cnt != dbase), 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_frame(input string tag);
    chk({tag, " nwrites"}, 32'(wcnt - wbase), 32'(NWR));
    for (int i = 0; i < NWR; i++) begin
      int p;
      p = i / 2;
      chk({tag, " addr"}, 32'(wr_addr[wbase+i]), 32'(p));
      chk({tag, " csel"}, 32'(wr_sel[wbase+i]), 32'(i % 2 + 1));
      chk({tag, " data"}, 32'(wr_data[wbase+i]), 32'((i % 2) ? exp1[p] : exp0[p]));
    end
  endtask

  initial begin
    int nw;
    reset = 1'b0; start = 1'b0; relu_en = 1'b0; kw_we = 1'b0; kw_addr = '0; kw_data = '0;
    for (int i = 0; i < NPIX; i++) img[i] = 20'h10000;
    repeat (3) tick();
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst cwr", 32'(cwr), 0);
    chk("rst csel", 32'(csel), 0);
    chk("rst iaddr", 32'(iaddr), 0);
    chk("rst caddr_wr", 32'(caddr_wr), 0);
    chk("rst cdata_wr", 32'(cdata_wr), 0);
    reset = 1'b1;
    tick();

    // Frame A: kernel 0 = 1.0 taps, kernel 1 = -0.5 taps, image 1.0; stray start mid-frame.
    load_kernel(2'd0, 20'h10000, 20'h00000);
    load_kernel(2'd1, 20'hF8000, 20'h00000);
    for (int p = 0; p < NPIX; p++) begin
      exp0[p] = (nbr(p) >= 8) ? 20'h7FFFF : 20'(nbr(p) * 32'h10000);
      exp1[p] = 20'(-(nbr(p) * 32'h8000));
    end
    run_frame(1'b0, 1);
    check_frame("A");
    chk("A (0,0) k0", 32'(wr_data[wbase+0]), 32'h40000);
    chk("A (0,0) k1", 32'(wr_data[wbase+1]), 32'hE0000);
    chk("A (0,1) k0", 32'(wr_data[wbase+2]), 32'h60000);
    chk("A (1,1) k0 sat", 32'(wr_data[wbase+10]), 32'h7FFFF);
    chk("A busy cycles", 32'(busy_cnt - bbase), 32'd352);
    chk("A done pulses", 32'(done_cnt - dbase), 32'd1);
    chk("A done cycle", 32'(done_cyc - s_cyc), 32'd353);
    for (int i = 0; i < NWR; i++)
      chk("A write cycle", 32'(wr_cyc[wbase+i] - s_cyc), 32'(11 * (i + 1)));

    // Frame B: same weights with ReLU.
    for (int p = 0; p < NPIX; p++) exp1[p] = '0;
    run_frame(1'b1, 0);
    check_frame("B");
    chk("B (0,0) k1 relu", 32'(wr_data[wbase+1]), 32'h00000);

    // Frame C: rounding, center tap = 1 LSB, image 0.5.
    for (int i = 0; i < NPIX; i++) img[i] = 20'h08000;
    load_kernel(2'd0, 20'h00000, 20'h00000);
    kw(2'd0, 4'd4, 20'h00001);
    for (int p = 0; p < NPIX; p++) begin
      exp0[p] = 20'h00001;
      exp1[p] = 20'(-(nbr(p) * 32'h4000));
    end
    run_frame(1'b0, 0);
    check_frame("C");

    // Frame D: bias -1 LSB loaded in the same cycle as start.
    for (int p = 0; p < NPIX; p++) exp0[p] = 20'h00000;
    run_frame(1'b0, 3);
    check_frame("D");

    // Frames E/F: weight load while busy is ignored, now and afterwards.
    run_frame(1'b0, 2);
    check_frame("E");
    run_frame(1'b0, 0);
    check_frame("F");

    // Reset at the 5th write of a frame.
    start = 1'b1; tick(); start = 1'b0;
    nw = 0;
    for (int n = 0; n < 200 && nw < 5; n++) begin
      if (cwr) nw++;
      if (nw < 5) tick();
    end
    chk("R five writes", 32'(nw), 32'd5);
    reset = 1'b0;
    tick();
    chk("R busy", 32'(busy), 0);
    chk("R cwr", 32'(cwr), 0);
    chk("R csel", 32'(csel), 0);
    chk("R done", 32'(done), 0);
    reset = 1'b1;
    wbase = wcnt;
    repeat (30) tick();
    chk("R no writes after abort", 32'(wcnt - wbase), 0);

    // Out-of-range kernel and slot loads are ignored; cleared weights give zeros.
    kw(2'd2, 4'd4, 20'h10000);
    kw(2'd3, 4'd4, 20'h10000);
    kw(2'd0, 4'd12, 20'h10000);
    for (int p = 0; p < NPIX; p++) begin
      exp0[p] = '0;
      exp1[p] = '0;
    end
    run_frame(1'b0, 0);
    check_frame("G");
    chk("csel nonzero without cwr", 32'(bad_csel), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
